// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the I/D line-miss arbiter in front of the single pmem port.
// Transactions are whole cache lines. Only one is outstanding at a time.
package cache_arbiter_pkg;

  localparam int ADDR_W           = 32;
  localparam int LINE_W           = 256;
  localparam int STREAK_W         = 4;
  localparam int MAX_D_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_RD = 1'b0,
    ARB_WR = 1'b1
  } arb_op_t;

  function automatic logic [STREAK_W-1:0] streak_sat_inc(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] max
  );
    return (cur >= max) ? max : cur + 1'b1;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Cache-side and memory-side line buses of the arbiter, bundled as one interface.
// The slave modport is the arbiter's view. The master modport is the caches' and memory's view.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter_select.sv
// Combinational D-priority pick with the I starvation guard, plus the next streak value.
// Zero latency. Only the grant sampled while the arbiter is idle has any effect.
module cache_arbiter_select
  import cache_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                i_read,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d,
  output arb_op_t             d_op,
  output logic [STREAK_W-1:0] streak_nxt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic d_pend;
  logic force_i;

  assign d_pend  = d_read | d_write;
  assign force_i = i_read & d_pend & (streak == STREAK_MAX);
  assign grant_i = i_read & (~d_pend | force_i);
  assign grant_d = d_pend & ~grant_i;
  // A simultaneous read+write is illegal. If it happens, it resolves as a writeback.
  assign d_op    = d_write ? ARB_WR : ARB_RD;

  always_comb begin
    streak_nxt = streak;
    if (grant_i) begin
      streak_nxt = '0;
    end else if (grant_d) begin
      streak_nxt = i_read ? streak_sat_inc(streak, STREAK_MAX) : '0;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem port between I and D line misses. Grant at the edge after a request; one RECOVER cycle follows each response.
// Requests are levels held until resp. pmem_read/write hold until pmem_resp, and a stray pmem_resp is ignored.
module cache_arbiter #(
  parameter int ADDR_W       = cache_arbiter_pkg::ADDR_W,
  parameter int LINE_W       = cache_arbiter_pkg::LINE_W,
  parameter int MAX_D_STREAK = cache_arbiter_pkg::MAX_D_STREAK_DEF
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  import cache_arbiter_pkg::*;

  arb_state_t          state_q, state_d;
  arb_op_t             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_nxt;
  logic                grant_i, grant_d;
  arb_op_t             d_op;
  logic                serving;

  cache_arbiter_select #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_select (
    .i_read     (bus.i_read),
    .d_read     (bus.d_read),
    .d_write    (bus.d_write),
    .streak     (streak_q),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .d_op       (d_op),
    .streak_nxt (streak_nxt)
  );

  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= ARB_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (grant_i || grant_d)) begin
        streak_q <= streak_nxt;
        if (grant_i) begin
          addr_q  <= bus.i_address;
          op_q    <= ARB_RD;
          wdata_q <= '0;
        end else begin
          addr_q  <= bus.d_address;
          op_q    <= d_op;
          wdata_q <= bus.d_wdata;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.i_resp     = 1'b0;
    bus.d_resp     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d = SERVE_I;
        end else if (grant_d) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        bus.pmem_read  = (op_q == ARB_RD);
        bus.pmem_write = (op_q == ARB_WR);
        bus.i_resp     = (state_q == SERVE_I) && bus.pmem_resp;
        bus.d_resp     = (state_q == SERVE_D) && bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_d = RECOVER;
        end
      end
      // One dead cycle lets the requester drop its level before IDLE samples it again.
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

  a_no_rd_and_wr_req: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !(bus.d_read && bus.d_write));

  a_pmem_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.pmem_read && bus.pmem_write));

  a_serving_req: assert property (@(posedge clk) disable iff (rst)
    serving |-> (bus.pmem_read ^ bus.pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench with an expected-transaction scoreboard on the pmem side and on the response side.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } pmem_exp_t;

  typedef struct {
    bit            is_d;
    bit            chk;
    logic [LW-1:0] rdata;
  } resp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   mem_en = 1'b1;
  int   lat = 3;
  int   mem_cnt = 0;
  logic [LW-1:0] mem_data = '0;
  pmem_exp_t pmem_q[$];
  resp_exp_t resp_q[$];

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_arbiter #(
    .ADDR_W       (AW),
    .LINE_W       (LW),
    .MAX_D_STREAK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pmem(input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] w);
    pmem_exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = w;
    pmem_q.push_back(e);
  endtask

  task automatic push_resp(input bit is_d, input bit chk, input logic [LW-1:0] r);
    resp_exp_t e;
    e.is_d = is_d; e.chk = chk; e.rdata = r;
    resp_q.push_back(e);
  endtask

  task automatic wait_resp(input bit is_d, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? bus.d_resp : bus.i_resp) && n < 40);
    check({name, "_resp_seen"}, LW'(is_d ? bus.d_resp : bus.i_resp), LW'(1));
  endtask

  // Memory model: respond after lat request cycles with mem_data.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if ((bus.pmem_read || bus.pmem_write) && !bus.pmem_resp) begin
          mem_cnt++;
          if (mem_cnt >= lat) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = mem_data;
            mem_cnt        = 0;
          end
        end else begin
          bus.pmem_resp  = 1'b0;
          bus.pmem_rdata = '0;
          mem_cnt        = 0;
        end
      end
    end
  end

  // pmem-side monitor: each new request is compared against the expected service order.
  initial begin
    bit prev = 1'b0;
    bit cur;
    pmem_exp_t e;
    forever begin
      @(negedge clk);
      cur = bus.pmem_read | bus.pmem_write;
      if (cur && !prev) begin
        check("pmem_excl", LW'(bus.pmem_read & bus.pmem_write), LW'(0));
        if (pmem_q.size() == 0) begin
          fail_now("pmem_unexpected_req");
        end else begin
          e = pmem_q.pop_front();
          check("pmem_op_wr", LW'(bus.pmem_write), LW'(e.wr));
          check("pmem_addr", LW'(bus.pmem_address), LW'(e.addr));
          if (e.wr) check("pmem_wdata", bus.pmem_wdata, e.wdata);
        end
      end
      prev = cur;
    end
  end

  // Response-side monitor.
  initial begin
    resp_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.i_resp || bus.d_resp) begin
        check("resp_excl", LW'(bus.i_resp & bus.d_resp), LW'(0));
        if (resp_q.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          e = resp_q.pop_front();
          check("resp_is_d", LW'(bus.d_resp), LW'(e.is_d));
          if (e.chk) check("resp_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", LW'(dut.state_q), LW'(IDLE));
    check("rst_streak", LW'(dut.streak_q), LW'(0));
    check("rst_pmem_read", LW'(bus.pmem_read), LW'(0));
    check("rst_pmem_write", LW'(bus.pmem_write), LW'(0));
    check("rst_pmem_addr", LW'(bus.pmem_address), LW'(0));
    check("rst_pmem_wdata", bus.pmem_wdata, '0);
    check("rst_resp", LW'({bus.i_resp, bus.d_resp}), LW'(0));
    rst = 1'b0;

    // Lone I read
    tick();
    lat = 3;
    mem_data = {32{8'hAA}};
    bus.i_address = 32'h0000_0060;
    bus.i_read = 1;
    push_pmem(0, 0, 32'h60, '0);
    push_resp(0, 1, {32{8'hAA}});
    @(negedge clk);
    check("t1_no_req_pre_grant", LW'(bus.pmem_read), LW'(0));
    @(negedge clk);
    check("t1_pmem_read", LW'(bus.pmem_read), LW'(1));
    check("t1_pmem_addr", LW'(bus.pmem_address), LW'(32'h60));
    wait_resp(0, "t1");
    tick();
    bus.i_read = 0;
    @(negedge clk);
    check("t1_recover", LW'(dut.state_q), LW'(RECOVER));
    check("t1_recover_quiet", LW'({bus.pmem_read, bus.i_resp}), LW'(0));
    @(negedge clk);
    check("t1_idle", LW'(dut.state_q), LW'(IDLE));

    // Simultaneous I read and D write: D first, I two quiet cycles after d_resp
    tick();
    mem_data = {32{8'hC3}};
    bus.i_address = 32'h100; bus.i_read = 1;
    bus.d_address = 32'h200; bus.d_wdata = {32{8'h55}}; bus.d_write = 1;
    push_pmem(1, 1, 32'h200, {32{8'h55}});
    push_resp(1, 0, '0);
    push_pmem(0, 0, 32'h100, '0);
    push_resp(0, 1, {32{8'hC3}});
    wait_resp(1, "t2_d");
    check("t2_streak_after_d", LW'(dut.streak_q), LW'(1));
    tick();
    bus.d_write = 0;
    @(negedge clk);
    check("t2_gap1", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
    @(negedge clk);
    check("t2_gap2", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
    @(negedge clk);
    check("t2_i_grant", LW'(bus.pmem_read), LW'(1));
    check("t2_streak_after_i", LW'(dut.streak_q), LW'(0));
    wait_resp(0, "t2_i");
    tick();
    bus.i_read = 0;

    // Starvation guard: four D grants, then I is forced
    tick();
    mem_data = {8{32'h1234_5678}};
    bus.i_address = 32'h400; bus.i_read = 1;
    bus.d_address = 32'h500; bus.d_read = 1;
    for (int k = 0; k < 4; k++) begin
      push_pmem(1, 0, 32'h500 + 32'(k) * 32'h20, '0);
      push_resp(1, 1, {8{32'h1234_5678}});
    end
    push_pmem(0, 0, 32'h400, '0);
    push_resp(0, 1, {8{32'h1234_5678}});
    push_pmem(1, 0, 32'h580, '0);
    push_resp(1, 1, {8{32'h1234_5678}});
    for (int k = 0; k < 4; k++) begin
      wait_resp(1, "t3_d");
      check("t3_streak", LW'(dut.streak_q), LW'(k + 1));
      tick();
      bus.d_address = 32'h500 + 32'(k + 1) * 32'h20;
    end
    wait_resp(0, "t3_i");
    check("t3_streak_clr", LW'(dut.streak_q), LW'(0));
    tick();
    bus.i_read = 0;
    wait_resp(1, "t3_d5");
    check("t3_streak_lone_d", LW'(dut.streak_q), LW'(0));
    tick();
    bus.d_read = 0;

    // Input stability: address change mid SERVE_D is ignored
    tick();
    lat = 4;
    mem_data = {8{32'hDEAD_BEEF}};
    bus.d_address = 32'h200; bus.d_read = 1;
    push_pmem(1, 0, 32'h200, '0);
    push_resp(1, 1, {8{32'hDEAD_BEEF}});
    @(negedge clk);
    @(negedge clk);
    check("t4_granted", LW'(bus.pmem_read), LW'(1));
    tick();
    bus.d_address = 32'h300;
    bus.d_wdata = {32{8'h99}};
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t4_addr_hold", LW'(bus.pmem_address), LW'(32'h200));
      check("t4_resp_timing", LW'(bus.d_resp), LW'(n == 2));
    end
    tick();
    bus.d_read = 0;

    // Stray pmem_resp while idle
    tick();
    mem_en = 0;
    bus.pmem_rdata = {32{8'hEE}};
    bus.pmem_resp = 1;
    @(negedge clk);
    check("t6_stray_resp", LW'({bus.i_resp, bus.d_resp}), LW'(0));
    check("t6_state", LW'(dut.state_q), LW'(IDLE));
    tick();
    bus.pmem_resp = 0;
    @(negedge clk);
    check("t6_state_after", LW'(dut.state_q), LW'(IDLE));
    check("t6_streak", LW'(dut.streak_q), LW'(0));

    // Async reset mid SERVE_I, then a stray response
    tick();
    bus.i_address = 32'h700; bus.i_read = 1;
    push_pmem(0, 0, 32'h700, '0);
    @(negedge clk);
    @(negedge clk);
    check("t5_serving", LW'(bus.pmem_read), LW'(1));
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_read_drop", LW'(bus.pmem_read), LW'(0));
    check("t5_rst_state", LW'(dut.state_q), LW'(IDLE));
    check("t5_rst_addr", LW'(bus.pmem_address), LW'(0));
    bus.i_read = 0;
    #1;
    rst = 1'b0;
    tick();
    bus.pmem_resp = 1;
    @(negedge clk);
    check("t5_no_i_resp", LW'(bus.i_resp), LW'(0));
    check("t5_state", LW'(dut.state_q), LW'(IDLE));
    tick();
    bus.pmem_resp = 0;

    repeat (3) tick();
    check("end_pmem_q_empty", LW'(pmem_q.size()), LW'(0));
    check("end_resp_q_empty", LW'(resp_q.size()), LW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
